uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter downstream of the single-cycle MIPS core's data-store path. Decodes the core's ALU-computed data address (before the 0x10000000 RAM rebase), accepts byte stores into a TX FIFO, and serialises bytes as 8N1 on `tx`. Status is readable combinationally in the same cycle, so the core's load path can poll it.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/uart_tx_mmio.sv | 156 +++++++++++++++
 tb/tb_uart_tx_mmio.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions and the transmitter state encoding.
package uart_pkg;

    localparam logic [2:0] UART_TXDATA = 3'd0;
    localparam logic [2:0] UART_STATUS = 3'd4;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: pop_data always presents the head entry so a
// consumer can capture it in the same cycle it pops. Pushes while full are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign count    = wr_ptr_reg - rd_ptr_reg;
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// 8N1 UART transmitter behind a two-word register window (TXDATA, STATUS) on the
// core's data-store path; status reads are combinational so loads can poll them.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          BAUD       = 115_200,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wren,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    logic [2:0]    reg_off;
    logic          wr_txdata;
    logic          wr_status;
    logic          push_ok;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [7:0]    fifo_data;
    logic [AW:0]   fifo_count;
    logic [7:0]    count8;
    logic          ovf_reg;
    logic          unused_bits;

    tx_state_t     state_reg;
    tx_state_t     state_next;
    logic [CW-1:0] div_cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          busy_reg;
    logic          bit_done;

    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
    assign reg_off   = {addr[2], 2'b00};
    assign wr_txdata = wren && sel && (reg_off == UART_TXDATA);
    assign wr_status = wren && sel && (reg_off == UART_STATUS);
    assign push_ok   = wr_txdata && !fifo_full;
    assign count8    = 8'(fifo_count);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .srst      (rst),
        .push      (wr_txdata),
        .push_data (wdata[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A push that meets a full FIFO is lost even if the FSM pops on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (wr_status) begin
            ovf_reg <= 1'b0;
        end else if (wr_txdata && fifo_full) begin
            ovf_reg <= 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel && reg_off == UART_STATUS) begin
            rdata[ST_EMPTY]              = fifo_empty;
            rdata[ST_FULL]               = fifo_full;
            rdata[ST_OVF]                = ovf_reg;
            rdata[ST_COUNT_LSB +: 8]     = count8;
        end
    end

    assign bit_done = (div_cnt_reg == DIV_LAST);
    // Popping from STOP's last cycle chains frames with no idle gap.
    assign fifo_pop = !fifo_empty &&
                      ((state_reg == IDLE) || (state_reg == STOP && bit_done));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!fifo_empty) state_next = START;
            START:   if (bit_done) state_next = DATA;
            DATA:    if (bit_done && bit_idx_reg == 3'd7) state_next = STOP;
            STOP:    if (bit_done) state_next = fifo_empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_reg)
            START:   tx = 1'b0;
            DATA:    tx = shift_reg[0];
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            busy_reg    <= 1'b0;
        end else begin
            if (state_reg == IDLE || bit_done) begin
                div_cnt_reg <= '0;
            end else begin
                div_cnt_reg <= div_cnt_reg + CW'(1);
            end

            if (fifo_pop) begin
                shift_reg <= fifo_data;
            end else if (state_reg == DATA && bit_done) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
            end

            if (state_reg == START) begin
                bit_idx_reg <= '0;
            end else if (state_reg == DATA && bit_done) begin
                bit_idx_reg <= bit_idx_reg + 3'd1;
            end

            busy_reg <= push_ok || !fifo_empty || (state_reg != IDLE);
        end
    end

    assign busy = busy_reg;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomised scoreboard bench for uart_tx_mmio: the driver predicts frame start
// cycles and FIFO occupancy; a line monitor decodes tx and checks each frame.
module tb_uart_tx_mmio;
    localparam int          CLK_HZ = 1_000_000;
    localparam int          BAUD   = 100_000;
    localparam int          DIV    = CLK_HZ / BAUD;
    localparam int          FRAME  = 10 * DIV;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h1000_FF00;

    typedef struct packed {
        int         start;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic        sel;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    int   pend_pop[$];
    int   last_start = -1000;
    logic m_ovf = 1'b0;
    int   flush_gen = 0;

    uart_tx_mmio #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .wren  (wren),
        .sel   (sel),
        .rdata (rdata),
        .tx    (tx),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // One bus cycle; the reference model is updated with what this cycle's edge does.
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we,
                         input logic r, input bit chk);
        int          n;
        int          occ;
        int          s;
        logic        exp_sel;
        logic [31:0] exp_rd;
        exp_t        e;
        @(negedge clk);
        addr  = a;
        wdata = d;
        wren  = we;
        rst   = r;
        #1;
        n = cyc;
        while (pend_pop.size() > 0 && pend_pop[0] < n) void'(pend_pop.pop_front());
        occ     = pend_pop.size();
        exp_sel = (a[31:3] == BASE[31:3]);
        exp_rd  = '0;
        if (exp_sel && a[2])
            exp_rd = {16'd0, 8'(occ), 5'd0, m_ovf, (occ == DEPTH), (occ == 0)};
        if (r) begin
            pend_pop.delete();
            exp_q.delete();
            last_start = -1000;
            m_ovf      = 1'b0;
            flush_gen++;
        end else begin
            if (chk) begin
                check("sel", 32'(sel), 32'(exp_sel));
                check("rdata", rdata, exp_rd);
            end
            if (we && exp_sel) begin
                if (a[2]) begin
                    m_ovf = 1'b0;
                end else if (occ >= DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    s = (n + 2 > last_start + FRAME) ? n + 2 : last_start + FRAME;
                    pend_pop.push_back(s - 1);
                    e.start = s;
                    e.data  = d[7:0];
                    exp_q.push_back(e);
                    last_start = s;
                end
            end
        end
    endtask

    task automatic idle();
        drive(BASE + 32'd4, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        drive(a, d, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic drain();
        while (cyc < last_start + FRAME + 5) idle();
    endtask

    // Line monitor: hunts for a start bit, samples mid-bit, checks against the queue.
    int         rx_start;
    int         seen_gen = 0;
    bit         rx_active = 0;
    logic [7:0] rx_byte;
    logic       rx_startbit;
    initial begin
        exp_t e;
        int   k;
        forever begin
            @(negedge clk);
            if (flush_gen != seen_gen) begin
                seen_gen  = flush_gen;
                rx_active = 0;
            end else if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1;
                    rx_start  = cyc;
                end
            end else begin
                k = cyc - rx_start;
                if (k % DIV == DIV / 2) begin
                    if (k / DIV == 0) begin
                        rx_startbit = tx;
                    end else if (k / DIV <= 8) begin
                        rx_byte[k / DIV - 1] = tx;
                    end else begin
                        rx_active = 0;
                        $display("[TB] frame 0x%02h start cycle %0d stop %b", rx_byte, rx_start, tx);
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_frame at cycle %0d: got byte 0x%02h, expected no frame",
                                     rx_start, rx_byte);
                        end else begin
                            e = exp_q.pop_front();
                            check("frame_bits", {22'd0, tx, rx_byte, rx_startbit},
                                  {22'd0, 1'b1, e.data, 1'b0});
                            check("frame_start", 32'(rx_start), 32'(e.start));
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst   = 1'b1;
        wren  = 1'b0;
        addr  = '0;
        wdata = '0;

        // Reset and idle: status must read 1 throughout.
        repeat (3) drive(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        repeat (50) idle();
        check("idle_tx", 32'(tx), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Single 0x55 frame and the busy fall cycle.
        store(BASE, 32'h55);
        idle();
        check("busy_rise", 32'(busy), 32'd1);
        while (cyc < last_start + FRAME) idle();
        check("busy_last", 32'(busy), 32'd1);
        check("tx_after_frame", 32'(tx), 32'd1);
        idle();
        check("busy_fall", 32'(busy), 32'd0);
        drain();

        // Back-to-back frames.
        store(BASE, 32'hA3);
        store(BASE + 32'd1, 32'h0F);
        drain();

        // Random bursts with random gaps and ignored low address bits.
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) store(BASE + 32'($urandom_range(0, 3)), $urandom);
            repeat ($urandom_range(0, 250)) idle();
        end
        drain();

        // Overfill: 18 back-to-back stores, then clear ovf through STATUS.
        for (int i = 0; i < DEPTH + 2; i++) store(BASE, $urandom);
        idle();
        check("ovf_set", 32'(rdata[2:1]), 32'd3);
        drive(BASE + 32'd4, $urandom, 1'b1, 1'b0, 1'b1);
        idle();
        check("ovf_clear", 32'(rdata[2]), 32'd0);
        drain();

        // Reset in the middle of data bit 4.
        store(BASE, $urandom);
        while (cyc < last_start + 5 * DIV + 2) idle();
        drive(BASE + 32'd4, 32'd0, 1'b0, 1'b1, 1'b0);
        idle();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2 * FRAME) idle();

        // Store outside the window: no push, line stays idle.
        store(32'h1000_0010, 32'h77);
        drive(32'h1000_0010, 32'd0, 1'b0, 1'b0, 1'b1);
        repeat (3 * FRAME) idle();
        check("offwin_tx", 32'(tx), 32'd1);
        check("offwin_busy", 32'(busy), 32'd0);

        check("all_frames_seen", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
